// File: rtl/game_pkg.sv
// Shared types and constants for the 4x4 two-player game sequencer.
package game_pkg;

    localparam int unsigned N_CELLS = 16;
    localparam int unsigned N_LINES = 10;

    typedef enum logic [1:0] {
        TURN  = 2'd0,
        CHECK = 2'd1,
        OVER  = 2'd2
    } state_t;

    localparam logic [1:0] W_NONE = 2'b00;
    localparam logic [1:0] W_P1   = 2'b01;
    localparam logic [1:0] W_P2   = 2'b10;
    localparam logic [1:0] W_DRAW = 2'b11;

    // Rows, columns, main diagonal, anti-diagonal.
    localparam logic [N_CELLS-1:0] WIN_LINES [N_LINES] = '{
        16'h000F, 16'h00F0, 16'h0F00, 16'hF000,
        16'h1111, 16'h2222, 16'h4444, 16'h8888,
        16'h8421, 16'h1248
    };

    function automatic logic [N_CELLS-1:0] cell_onehot(input logic [3:0] idx);
        cell_onehot      = '0;
        cell_onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/game_turn_ctrl_line_detect.sv
// Combinational four-in-a-row detector over one player's ownership mask.
module line_detect
    import game_pkg::*;
(
    input  logic [N_CELLS-1:0] mask,
    output logic               win
);

    always_comb begin
        win = 1'b0;
        for (int i = 0; i < int'(N_LINES); i++) begin
            if ((mask & WIN_LINES[i]) == WIN_LINES[i]) begin
                win = 1'b1;
            end
        end
    end

endmodule

// File: rtl/game_turn_ctrl.sv
// Turn sequencer for a 4x4 four-in-a-row game: move validation, win/draw detection.
// Optional per-turn move deadline enabled by defining MOVE_TIMEOUT_EN.
module game_turn_ctrl
    import game_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               new_game,
    input  logic               play,
    input  logic [3:0]         pos,
    output logic [N_CELLS-1:0] p1_mask,
    output logic [N_CELLS-1:0] p2_mask,
    output logic               turn,
    output logic [N_CELLS-1:0] cell_we,
    output logic               illegal,
    output logic [1:0]         winner,
    output logic               game_over
`ifdef MOVE_TIMEOUT_EN
    ,
    output logic               timeout
`endif
);

    state_t             state;
    logic [N_CELLS-1:0] occupied;
    logic [N_CELLS-1:0] mover_mask;
    logic               mover_win;
`ifdef MOVE_TIMEOUT_EN
    logic [31:0]        tcnt;
`endif

    assign occupied   = p1_mask | p2_mask;
    // In CHECK the mover's register already holds the newly placed stone.
    assign mover_mask = turn ? p2_mask : p1_mask;

    line_detect u_line_detect (
        .mask (mover_mask),
        .win  (mover_win)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= TURN;
            p1_mask   <= '0;
            p2_mask   <= '0;
            turn      <= 1'b0;
            cell_we   <= '0;
            illegal   <= 1'b0;
            winner    <= W_NONE;
            game_over <= 1'b0;
`ifdef MOVE_TIMEOUT_EN
            tcnt      <= '0;
            timeout   <= 1'b0;
`endif
        end else begin
            cell_we <= '0;
            illegal <= 1'b0;
`ifdef MOVE_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            if (new_game) begin
                state     <= TURN;
                p1_mask   <= '0;
                p2_mask   <= '0;
                turn      <= 1'b0;
                winner    <= W_NONE;
                game_over <= 1'b0;
`ifdef MOVE_TIMEOUT_EN
                tcnt      <= '0;
`endif
            end else begin
                unique case (state)
                    TURN: begin
                        if (play && !occupied[pos]) begin
                            if (turn) p2_mask[pos] <= 1'b1;
                            else      p1_mask[pos] <= 1'b1;
                            cell_we <= cell_onehot(pos);
                            state   <= CHECK;
                        end else begin
                            if (play) illegal <= 1'b1;
`ifdef MOVE_TIMEOUT_EN
                            if (tcnt == TIMEOUT_CYCLES - 32'd1) begin
                                turn    <= ~turn;
                                tcnt    <= '0;
                                timeout <= 1'b1;
                            end else begin
                                tcnt <= tcnt + 32'd1;
                            end
`endif
                        end
                    end
                    CHECK: begin
                        if (mover_win) begin
                            winner    <= turn ? W_P2 : W_P1;
                            game_over <= 1'b1;
                            state     <= OVER;
                        end else if (&occupied) begin
                            winner    <= W_DRAW;
                            game_over <= 1'b1;
                            state     <= OVER;
                        end else begin
                            turn  <= ~turn;
                            state <= TURN;
`ifdef MOVE_TIMEOUT_EN
                            tcnt  <= '0;
`endif
                        end
                    end
                    OVER: begin
                        game_over <= 1'b1;
                    end
                    default: state <= TURN;
                endcase
            end
        end
    end

endmodule
